sync_fifo_flags: RTL and testbench
==================================

# sync_fifo_flags

Parametrised synchronous FIFO, the next generation of the team's single-clock FIFO. Adds full-depth usage (all DEPTH entries usable), an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a selectable read mode: standard registered read or first-word-fall-through (FWFT). Sits between single-clock producer/consumer stages, such as UART RX/TX paths and display/command queues.

## Interface
- DEPTH, 8: number of entries; power of 2, ≥ 2.
- DATA_WIDTH, 8: word width.
- FWFT, 0: 0 = standard read, 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-1: almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 1: almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- nrst  in  1  reset, synchronous, active-low.
- clr  in  1  synchronous flush; lower priority than nrst.
- w_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- r_en  in  1  read request in standard mode; pop/acknowledge in FWFT mode.
- data_out  out  DATA_WIDTH  read data.
- rd_valid  out  1  data_out holds valid data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
- Pointers w_ptr and r_ptr are $clog2(DEPTH)+1 bits wide.
  - Memory is addressed by the low bits.
  - The MSB is a wrap bit.
  - full = (MSBs differ) && (low bits equal).
  - empty = (pointers equal).
- Write accepted: w_en && !full. Writes data_in to mem[w_ptr] and increments w_ptr modulo 2·DEPTH.
- Read accepted: r_en && !empty. Increments r_ptr.
- There is no bypass in either direction:
  - w_en while full is rejected, even if a read is accepted in the same cycle.
  - r_en while empty is rejected, even if a write is accepted in the same cycle.
- count is a register:
  - +1 on a write only.
  - −1 on a read only.
  - Unchanged when both or neither are accepted.
- Error flags:
  - w_en && full sets overflow.
  - r_en && empty sets underflow.
  - Both stay set until nrst or clr.
- Standard mode (FWFT=0):
  - On an accepted read, data_out <= mem[r_ptr] and rd_valid <= 1.
  - Otherwise rd_valid <= 0 and data_out holds its value.
- FWFT mode (FWFT=1):
  - data_out = empty ? 0 : mem[r_ptr] (combinational).
  - rd_valid = !empty.
  - An accepted r_en pops the head word.
- clr:
  - Sets pointers, count, overflow, underflow and rd_valid to 0.
  - In standard mode also sets data_out to 0.
  - Memory contents are not cleared.
  - w_en and r_en are ignored in a clr cycle.
- nrst low: same effect as clr, and takes precedence over it.
- Reset values: data_out 0, rd_valid 0, count 0, full 0, empty 1, almost_empty 1, almost_full 0, overflow 0, underflow 0.

## Timing
- full, empty, almost_full and almost_empty are decoded combinationally from registered state. They reflect an accepted operation the cycle after its edge.
- Standard mode latency: data is on data_out one cycle after the r_en edge, qualified by rd_valid.
- FWFT mode latency: a word written into an empty FIFO at edge N appears on data_out, with rd_valid = 1, after edge N, i.e. zero extra cycles.
- Wrap-around: pointers roll from 2·DEPTH−1 to 0 with no gap. Sustained simultaneous reads and writes at any occupancy between 1 and DEPTH−1 keep count constant.
- A reset or clr asserted mid-burst takes effect at the next edge. Any data in flight is discarded.

## Structure
- Shared package fifo_pkg holds:
  - the mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1;
  - a ptr-width function, $clog2(DEPTH)+1, reused by future FIFO variants.
- One sub-module, fifo_mem: a DEPTH × DATA_WIDTH simple dual-port array.
  - Synchronous write port.
  - Asynchronous read port.
- Pointer, count and flag logic stay in the top level.

## Test plan
All scenarios use DEPTH=8 and DATA_WIDTH=8.
- Reset: hold nrst=0 for 2 cycles → count=0, empty=1, full=0, almost_empty=1, data_out=0, overflow=0, underflow=0.
- Fill/drain, FWFT=0: write 0x01..0x08 → full=1 and count=8 after the 8th edge. A 9th write sets overflow=1 and count stays 8. Read 8 times → data_out 0x01..0x08, each one cycle after its r_en, then empty=1. One more r_en sets underflow=1.
- FWFT=1: write 0xA5 into the empty FIFO → data_out=0xA5 and rd_valid=1 on the next cycle with no r_en. Pulse r_en → empty=1 and data_out=0.
- Thresholds, AF_LEVEL=6 and AE_LEVEL=2: almost_empty deasserts at count 3. almost_full asserts at count 6 and deasserts when count drops to 5.
- Wrap/simultaneous: hold 4 entries, then run 20 cycles of w_en=r_en=1 with an incrementing pattern → count stays 4, the data order is preserved and pointers wrap. Simultaneous w_en and r_en while empty → the write is accepted, underflow=1 and count becomes 1.
- Flush: assert clr with 5 entries stored and w_en=1 → count=0, empty=1 and flags cleared. The write in the clr cycle is ignored.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the single-clock FIFO family
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Pointer width: address bits plus one wrap bit to tell full from empty
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH simple dual-port array, sync write, async read
module fifo_mem #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset; the pointers decide what is valid
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with count, thresholds, sticky errors, flush and FWFT option
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FWFT       = FIFO_MODE_STD,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    localparam int PW        = ptr_width(DEPTH),
    localparam int AW        = PW - 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  clr,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    logic [PW-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d, count_q, count_d;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          wr_acc, rd_acc, flush;
    logic [DATA_WIDTH-1:0] rd_data;

    assign flush  = !nrst || clr;
    assign full   = (w_ptr_q[PW-1] != r_ptr_q[PW-1]) && (w_ptr_q[AW-1:0] == r_ptr_q[AW-1:0]);
    assign empty  = w_ptr_q == r_ptr_q;
    assign wr_acc = w_en && !full;
    assign rd_acc = r_en && !empty;

    assign almost_full  = count_q >= PW'(AF_LEVEL);
    assign almost_empty = count_q <= PW'(AE_LEVEL);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // Next-state for pointers, occupancy and sticky error flags; no bypass either way
    always_comb begin
        w_ptr_d = w_ptr_q + PW'(wr_acc);
        r_ptr_d = r_ptr_q + PW'(rd_acc);
        count_d = (wr_acc && !rd_acc) ? count_q + PW'(1) :
                  (rd_acc && !wr_acc) ? count_q - PW'(1) : count_q;
        ovf_d   = ovf_q || (w_en && full);
        udf_d   = udf_q || (r_en && empty);
    end

    // Register state; reset and flush both discard everything in flight
    always_ff @(posedge clk) begin
        if (flush) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc && !flush),
        .waddr_i (w_ptr_q[AW-1:0]),
        .wdata_i (data_in),
        .raddr_i (r_ptr_q[AW-1:0]),
        .rdata_o (rd_data)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign data_out = empty ? '0 : rd_data;
            assign rd_valid = !empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  valid_q;
            // Registered read port: data appears the cycle after an accepted read
            always_ff @(posedge clk) begin
                if (flush) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    dout_q  <= rd_acc ? rd_data : dout_q;
                    valid_q <= rd_acc;
                end
            end
            assign data_out = dout_q;
            assign rd_valid = valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed and random checks of both read modes against a queue model
module tb_sync_fifo_flags;

    logic clk = 1'b0;
    logic nrst = 1'b0, clr = 1'b0, w_en = 1'b0, r_en = 1'b0;
    logic [7:0] data_in = '0;

    logic [7:0] s_dout, f_dout;
    logic [3:0] s_cnt, f_cnt;
    logic s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;

    int total = 0;
    int bad = 0;

    byte unsigned q[$];
    bit m_ovf, m_udf, m_sv;
    logic [7:0] m_sd;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DEPTH(8), .DATA_WIDTH(8), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)) u_std (
        .clk(clk), .nrst(nrst), .clr(clr), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(s_dout), .rd_valid(s_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt), .overflow(s_ovf), .underflow(s_udf)
    );

    sync_fifo_flags #(.DEPTH(8), .DATA_WIDTH(8), .FWFT(1)) u_fw (
        .clk(clk), .nrst(nrst), .clr(clr), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(f_dout), .rd_valid(f_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt), .overflow(f_ovf), .underflow(f_udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: a queue of words plus the sticky flags and the std read register
    task automatic model(input logic w, input logic r, input logic c, input logic n, input logic [7:0] d);
        int sz;
        sz = q.size();
        if (!n || c) begin
            q.delete();
            m_ovf = 0; m_udf = 0; m_sv = 0; m_sd = 8'h00;
        end else begin
            if (w && sz == 8) m_ovf = 1;
            if (r && sz == 0) m_udf = 1;
            m_sv = r && sz != 0;
            if (m_sv) m_sd = q.pop_front();
            if (w && sz != 8) q.push_back(d);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        chk("std_count", 32'(s_cnt), 32'(sz));
        chk("std_full", 32'(s_full), 32'(sz == 8));
        chk("std_empty", 32'(s_empty), 32'(sz == 0));
        chk("std_af", 32'(s_af), 32'(sz >= 6));
        chk("std_ae", 32'(s_ae), 32'(sz <= 2));
        chk("std_ovf", 32'(s_ovf), 32'(m_ovf));
        chk("std_udf", 32'(s_udf), 32'(m_udf));
        chk("std_valid", 32'(s_valid), 32'(m_sv));
        chk("std_dout", 32'(s_dout), 32'(m_sd));
        chk("fw_count", 32'(f_cnt), 32'(sz));
        chk("fw_full", 32'(f_full), 32'(sz == 8));
        chk("fw_empty", 32'(f_empty), 32'(sz == 0));
        chk("fw_af", 32'(f_af), 32'(sz >= 7));
        chk("fw_ae", 32'(f_ae), 32'(sz <= 1));
        chk("fw_ovf", 32'(f_ovf), 32'(m_ovf));
        chk("fw_udf", 32'(f_udf), 32'(m_udf));
        chk("fw_valid", 32'(f_valid), 32'(sz != 0));
        chk("fw_dout", 32'(f_dout), sz != 0 ? 32'(q[0]) : 32'h0);
    endtask

    task automatic step(input logic w, input logic r, input logic c, input logic n, input logic [7:0] d);
        @(negedge clk);
        w_en = w; r_en = r; clr = c; nrst = n; data_in = d;
        @(posedge clk);
        model(w, r, c, n, d);
        #1;
        check_all();
    endtask

    initial begin
        int pw, pr;
        // Reset held for two cycles
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        chk("rst_count", 32'(s_cnt), 32'h0);
        chk("rst_ae", 32'(s_ae), 32'h1);
        // Fill 0x01..0x08, then one write too many
        for (int i = 1; i <= 8; i++) step(1, 0, 0, 1, 8'(i));
        chk("fill_full", 32'(s_full), 32'h1);
        step(1, 0, 0, 1, 8'h09);
        chk("ovf_set", 32'(s_ovf), 32'h1);
        chk("ovf_count", 32'(s_cnt), 32'h8);
        // Drain in order, then one read too many
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 0, 1, 8'h00);
            chk("drain_data", 32'(s_dout), 32'(i));
        end
        step(0, 1, 0, 1, 8'h00);
        chk("udf_set", 32'(s_udf), 32'h1);
        // FWFT fall-through of a single word
        step(0, 0, 1, 1, 8'h00);
        step(1, 0, 0, 1, 8'hA5);
        chk("fwft_head", 32'(f_dout), 32'hA5);
        chk("fwft_valid", 32'(f_valid), 32'h1);
        step(0, 1, 0, 1, 8'h00);
        chk("fwft_pop_dout", 32'(f_dout), 32'h0);
        // Threshold ramp up to 7 and back down to 0
        for (int i = 0; i < 7; i++) step(1, 0, 0, 1, 8'(8'h30 + i));
        for (int i = 0; i < 7; i++) step(0, 1, 0, 1, 8'h00);
        // Hold 4 entries and stream 20 simultaneous read/write cycles across the wrap
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 8'(8'h40 + i));
        for (int i = 4; i < 24; i++) step(1, 1, 0, 1, 8'(8'h40 + i));
        chk("wrap_count", 32'(s_cnt), 32'h4);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 8'h00);
        // Simultaneous read and write while empty: write wins, underflow recorded
        step(1, 1, 0, 1, 8'h77);
        chk("empty_rw_count", 32'(s_cnt), 32'h1);
        // Flush with data stored and a write presented in the same cycle
        step(0, 0, 1, 1, 8'h00);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 8'(8'h50 + i));
        step(1, 0, 1, 1, 8'hEE);
        chk("flush_empty", 32'(s_empty), 32'h1);
        // Random traffic with varying read/write bias, occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                pw = $urandom_range(1, 9);
                pr = 10 - pw;
            end
            step($urandom_range(0, 9) < pw, $urandom_range(0, 9) < pr,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 79) != 0, 8'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
